// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_port_arbiter
// Purpose : Shares one single-port data RAM between two requesters.
//             port 0 : control unit (fetch, operand load, store)
//             port 1 : host loader / debug (program load, result readout)
//           One RAM transaction per grant. Round-robin on a tie by default,
//           so a busy CPU cannot starve the host. This block is the only
//           driver of the RAM address/data/write-enable pins.
// Config  : define ARB_FIXED_PRIO_EN to make port 0 win every tie
//           (round-robin when undefined).
// Ports   : clock, reset            - clock, synchronous active-high reset
//           req*/we*/addr*/wdata*   - request + command, held until gnt*
//           gnt*                    - 1-cycle pulse, command captured
//           rvalid*/rdata*          - read data pulse / held read data
//           done*                   - 1-cycle pulse, transaction finished
//           mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - RAM interface
//           busy                    - transaction in progress
//           gcnt0/gcnt1             - saturating per-port grant counters
// Timing  : req->gnt 1 cycle (idle), write req->done 3, read req->rvalid 4.
// Revision: 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              done0,
  output logic              done1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        gcnt0,
  output logic [7:0]        gcnt1
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2
  } state_t;

  state_t state;
  logic   last;    // port granted most recently
  logic   owner;   // port owning the transaction in flight
  logic   issued;  // ACCESS has already strobed the RAM
  logic   cap_we;  // captured write/read command
  logic   pick;    // winner if a grant is issued this cycle

`ifdef ARB_FIXED_PRIO_EN
  // Port 0 always wins; the host is served only while req0 is low.
  always_comb begin
    pick = ~req0;
  end
`else
  // On a tie, serve the port that was not served last.
  always_comb begin
    pick = (req0 && req1) ? ~last : req1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      issued    <= 1'b0;
      cap_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      gcnt0     <= 8'h00;
      gcnt1     <= 8'h00;
    end else begin
      // Pulse outputs default low every cycle.
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      case (state)
        ST_IDLE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (req0 || req1) begin
            owner  <= pick;
            last   <= pick;
            issued <= 1'b0;
            state  <= ST_ACCESS;
            busy   <= 1'b1;
            if (pick) begin
              mem_addr  <= addr1;
              mem_wdata <= wdata1;
              cap_we    <= we1;
              gnt1      <= 1'b1;
              if (gcnt1 != 8'hFF) gcnt1 <= gcnt1 + 8'd1;
            end else begin
              mem_addr  <= addr0;
              mem_wdata <= wdata0;
              cap_we    <= we0;
              gnt0      <= 1'b1;
              if (gcnt0 != 8'hFF) gcnt0 <= gcnt0 + 8'd1;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        // First cycle strobes the RAM; second cycle ends a write or hands a
        // read over to READ_WAIT, where the synchronous RAM output is valid.
        ST_ACCESS: begin
          if (!issued) begin
            mem_en <= 1'b1;
            mem_we <= cap_we;
            issued <= 1'b1;
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (cap_we) begin
              if (owner) done1 <= 1'b1;
              else       done0 <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_READ_WAIT;
            end
          end
        end

        ST_READ_WAIT: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (owner) begin
            rdata1  <= mem_rdata;
            rvalid1 <= 1'b1;
            done1   <= 1'b1;
          end else begin
            rdata0  <= mem_rdata;
            rvalid0 <= 1'b1;
            done0   <= 1'b1;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= ST_IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_ram_port_arbiter
// Purpose : Randomized self-checking bench for ram_port_arbiter. Two random
//           requesters, a behavioural RAM, a transaction-level reference
//           model that predicts grants/latencies, and a scoreboard monitor
//           that pops expected responses when done* pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, rvalid0, rvalid1, done0, done1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, gcnt0, gcnt1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .done0(done0), .done1(done1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .gcnt0(gcnt0), .gcnt1(gcnt1)
  );

  // Behavioural synchronous single-port RAM
  logic [7:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requesters ----------------
  bit en [2]     = '{0, 0};
  bit hold [2]   = '{0, 0};
  bit rdonly [2] = '{0, 0};
  int waitc0 = 0, waitc1 = 0;

  task automatic step_port(input int p, input logic gnt, inout logic rq, inout logic w,
                           inout logic [7:0] a, inout logic [7:0] d, inout int waitc);
    bit go;
    if (rq && !gnt) begin
      waitc++;
      if (waitc > 1000) begin
        checks++;
        errors++;
        $display("FAIL req_timeout port %0d: waited %0d cycles, required <= 1000", p, waitc);
        waitc = 0;
        rq = 1'b0;
      end
    end else begin
      go = en[p] && (hold[p] || ($urandom_range(0, 3) == 0));
      if (go) begin
        rq    = 1'b1;
        w     = rdonly[p] ? 1'b0 : 1'($urandom_range(0, 1));
        a     = 8'($urandom_range(0, 15));
        d     = 8'($urandom);
        waitc = 0;
      end else begin
        rq = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clock); #2;
    step_port(0, gnt0, req0, we0, addr0, wdata0, waitc0);
  end
  initial forever begin
    @(posedge clock); #2;
    step_port(1, gnt1, req1, we1, addr1, wdata1, waitc1);
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       is_rd;
    logic [7:0] data;
    int         dcyc;
  } exp_t;

  exp_t       q0[$], q1[$];
  logic [7:0] ref_mem [0:255];
  logic [7:0] gc [2] = '{8'h00, 8'h00};
  int         tot_g0 = 0;
  int         cyc = 0, g_cyc = 0, done_cyc = 0;
  bit         in_flight = 0, owner = 0, last_m = 1;
  logic       cur_we;
  logic [7:0] cur_addr, cur_wdata;
  logic       rst_snap = 1'b1;
  logic       ps_req [2] = '{1'b0, 1'b0};
  logic       ps_we [2];
  logic [7:0] ps_addr [2], ps_wdata [2];

  always @(negedge clock) begin : model
    logic [1:0] exp_g;
    bit win;
    exp_t e;
    cyc++;
    if (rst_snap) begin
      chk("reset_outs", {gnt0, gnt1, done0, done1, rvalid0, rvalid1, mem_en, mem_we, busy,
                         rdata0, rdata1, gcnt0, gcnt1}, 64'd0);
      in_flight = 0;
      last_m    = 1;
      gc[0]     = 8'h00;
      gc[1]     = 8'h00;
      q0.delete();
      q1.delete();
    end else begin
      exp_g = 2'b00;
      win   = 0;
      if (!in_flight && (ps_req[0] || ps_req[1])) begin
`ifdef ARB_FIXED_PRIO_EN
        win = !ps_req[0];
`else
        win = (ps_req[0] && ps_req[1]) ? !last_m : ps_req[1];
`endif
        exp_g = win ? 2'b01 : 2'b10;
      end
      chk("grant", {gnt0, gnt1}, 64'(exp_g));
      if (exp_g != 2'b00) begin
        owner     = win;
        last_m    = win;
        in_flight = 1;
        g_cyc     = cyc;
        cur_we    = ps_we[win];
        cur_addr  = ps_addr[win];
        cur_wdata = ps_wdata[win];
        done_cyc  = cyc + (cur_we ? 2 : 3);
        if (gc[win] != 8'hFF) gc[win] = gc[win] + 8'd1;
        if (!win) tot_g0++;
        e.is_rd = !cur_we;
        e.data  = ref_mem[cur_addr];
        e.dcyc  = done_cyc;
        if (cur_we) ref_mem[cur_addr] = cur_wdata;
        if (win) q1.push_back(e);
        else     q0.push_back(e);
        chk("busy_at_grant", {busy, mem_en}, 64'b10);
      end else if (in_flight) begin
        chk("mem_en", mem_en, 64'(cyc == g_cyc + 1));
        if (cyc == g_cyc + 1)
          chk("mem_cmd", {mem_we, mem_addr, mem_wdata}, {cur_we, cur_addr, cur_wdata});
        chk("done", {done0, done1}, (cyc == done_cyc) ? (owner ? 64'b01 : 64'b10) : 64'b00);
        chk("busy", busy, 64'(cyc < done_cyc));
        if (cyc == done_cyc) in_flight = 0;
      end else begin
        chk("idle_outs", {mem_en, busy, done0, done1, rvalid0, rvalid1}, 64'd0);
      end
      chk("mem_we_gate", mem_we & ~mem_en, 64'd0);
      chk("gcnt", {gcnt0, gcnt1}, {gc[0], gc[1]});
    end
    rst_snap    = reset;
    ps_req[0]   = req0;   ps_req[1]   = req1;
    ps_we[0]    = we0;    ps_we[1]    = we1;
    ps_addr[0]  = addr0;  ps_addr[1]  = addr1;
    ps_wdata[0] = wdata0; ps_wdata[1] = wdata1;
  end

  // ---------------- scoreboard monitor ----------------
  int         cyc_c = 0;
  logic       rs_c = 1'b1;
  logic [7:0] held [2] = '{8'h00, 8'h00};

  always @(negedge clock) begin : monitor
    exp_t e;
    logic d, rv;
    logic [7:0] rd;
    cyc_c++;
    if (rs_c) begin
      held[0] = 8'h00;
      held[1] = 8'h00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        d  = p ? done1   : done0;
        rv = p ? rvalid1 : rvalid0;
        rd = p ? rdata1  : rdata0;
        if (d) begin
          if ((p ? q1.size() : q0.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done port %0d: got done with empty queue, required none", p);
          end else begin
            e = p ? q1.pop_front() : q0.pop_front();
            chk("done_time", 64'(cyc_c), 64'(e.dcyc));
            chk("rvalid", rv, 64'(e.is_rd));
            if (e.is_rd) begin
              chk("rdata", rd, 64'(e.data));
              held[p] = e.data;
            end
          end
        end else begin
          chk("rvalid_idle", rv, 64'd0);
        end
        chk("rdata_hold", rd, 64'(held[p]));
      end
    end
    rs_c = reset;
  end

  // ---------------- sequencing ----------------
  task automatic drain();
    int n;
    en[0] = 0; en[1] = 0; hold[0] = 0; hold[1] = 0; rdonly[0] = 0; rdonly[1] = 0;
    n = 0;
    do begin
      @(posedge clock); #2;
      n++;
    end while ((req0 || req1 || in_flight) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin : main
    logic [7:0] v;
    int n, start;
    bit found;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ram[i]     = v;
      ref_mem[i] = v;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // random traffic from both ports
    en[0] = 1; en[1] = 1;
    repeat (400) @(posedge clock);
    drain();

    // both ports requesting continuously
    en[0] = 1; en[1] = 1; hold[0] = 1; hold[1] = 1;
    repeat (150) @(posedge clock);
    drain();

    // reset while a read waits for RAM data
    en[0] = 1; en[1] = 1;
    found = 0;
    n = 0;
    while (!found && n < 1000) begin
      @(posedge clock); #2;
      n++;
      if (in_flight && !cur_we && cyc == g_cyc + 1) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL reset_window: no read found in %0d cycles, required one", n);
    end else begin
      reset = 1'b1;
      @(posedge clock); #2;
      reset = 1'b0;
    end
    repeat (200) @(posedge clock);
    drain();

    // 300 back-to-back port-0 reads saturate its grant counter
    en[0] = 1; hold[0] = 1; rdonly[0] = 1;
    start = tot_g0;
    n = 0;
    while (tot_g0 < start + 300 && n < 5000) begin
      @(posedge clock); #2;
      n++;
    end
    drain();
    chk("gcnt0_saturated", gcnt0, 64'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
